// File: rtl/hq_fifo_pkg.sv
// Shared types and constants for the HQ message-channel reader: frame layout,
// output buffer entry, reader FSM states and the ring offset advance rule.
package hq_fifo_pkg;

    localparam logic [63:0] MSG_CONSTANT = 64'h4851_4D53_475F_4331;

    typedef struct packed {
        logic [63:0]  magic;
        logic [63:0]  counter;
        logic [63:0]  offset;
        logic [63:0]  rsvd;
        logic [255:0] payload;
    } hq_msg_t;

    typedef struct packed {
        logic [255:0] payload;
        logic         seq_err;
    } rd_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } reader_state_e;

    // Offset the writer uses after `off`; a zero capacity behaves as a one-slot ring.
    function automatic logic [63:0] next_offset(input logic [63:0] off,
                                                input logic [63:0] cap_raw);
        logic [63:0] cap;
        logic [63:0] inc;
        cap = (cap_raw == 64'd0) ? 64'd1 : cap_raw;
        inc = off + 64'd1;
        return (inc < cap) ? inc : 64'd0;
    endfunction

endpackage

// File: rtl/hq_fifo_reader_buf.sv
// Two-entry output FIFO holding {payload, seq_err}; head entry drives the
// consumer stream and the write side never depends on the read request.
module hq_fifo_reader_buf
    import hq_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  rd_entry_t  wr_data_i,
    input  logic       rd_en_i,
    output rd_entry_t  rd_data_o,
    output logic       rd_valid_o,
    output logic [1:0] count_o
);

    rd_entry_t  mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_wr, do_rd;

    assign do_wr = wr_en_i && (count_q != 2'd2);
    assign do_rd = rd_en_i && (count_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 2'd1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Stale entries are masked so an empty buffer always presents zeros.
    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/hq_fifo_reader.sv
// HQ RX-channel consumer: pops framed messages, checks MSG_CONSTANT (and, with
// HQ_FIFO_READER_CHECK_EN defined, the counter/offset sequence) and streams payloads.
module hq_fifo_reader
    import hq_fifo_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit HALT_ON_ERR = 1'b0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [511:0]     rx_data_i,
    input  logic             rx_empty_i,
    output logic             rx_pop_o,
    input  logic [63:0]      rd_capacity_i,
    output logic [255:0]     rd_msg_o,
    output logic             rd_seq_err_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [CNT_W-1:0] err_magic_o,
    output logic [CNT_W-1:0] err_seq_o,
    output logic [CNT_W-1:0] err_off_o,
    output logic             halted_o
);

    hq_msg_t          msg;
    reader_state_e    state_q, state_d;
    logic [CNT_W-1:0] err_magic_q, err_magic_d;
    logic [1:0]       buf_count;
    logic             magic_ok, seq_bad, off_bad, frame_err;
    rd_entry_t        wr_entry, rd_entry;

    assign msg      = hq_msg_t'(rx_data_i);
    assign magic_ok = (msg.magic == MSG_CONSTANT);

    // Reset also gates the pop so the channel head survives a mid-stream reset.
    assign rx_pop_o  = !rst && !rx_empty_i && (state_q == RUN) && (buf_count < 2'd2);
    assign frame_err = rx_pop_o && (!magic_ok || seq_bad || off_bad);

`ifdef HQ_FIFO_READER_CHECK_EN
    logic [63:0]      exp_cnt_q, exp_cnt_d;
    logic [63:0]      exp_off_q, exp_off_d;
    logic [CNT_W-1:0] err_seq_q, err_seq_d;
    logic [CNT_W-1:0] err_off_q, err_off_d;
    logic             unused_rsvd;

    assign unused_rsvd = ^msg.rsvd;
    assign seq_bad     = magic_ok && (msg.counter != exp_cnt_q);
    assign off_bad     = magic_ok && (msg.offset != exp_off_q);

    // Expectations resync to whatever a well-framed message carried.
    always_comb begin
        exp_cnt_d = exp_cnt_q;
        exp_off_d = exp_off_q;
        err_seq_d = err_seq_q;
        err_off_d = err_off_q;
        if (rx_pop_o && magic_ok) begin
            exp_cnt_d = msg.counter + 64'd1;
            exp_off_d = next_offset(msg.offset, rd_capacity_i);
        end
        if (rx_pop_o && seq_bad && (err_seq_q != '1)) begin
            err_seq_d = err_seq_q + CNT_W'(1);
        end
        if (rx_pop_o && off_bad && (err_off_q != '1)) begin
            err_off_d = err_off_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_cnt_q <= 64'd1;
            exp_off_q <= 64'd0;
            err_seq_q <= '0;
            err_off_q <= '0;
        end else begin
            exp_cnt_q <= exp_cnt_d;
            exp_off_q <= exp_off_d;
            err_seq_q <= err_seq_d;
            err_off_q <= err_off_d;
        end
    end

    assign err_seq_o = err_seq_q;
    assign err_off_o = err_off_q;
`else
    logic unused_fields;

    assign unused_fields = ^{msg.counter, msg.offset, msg.rsvd, rd_capacity_i};
    assign seq_bad       = 1'b0;
    assign off_bad       = 1'b0;
    assign err_seq_o     = '0;
    assign err_off_o     = '0;
`endif

    always_comb begin
        state_d     = state_q;
        err_magic_d = err_magic_q;
        if (rx_pop_o && !magic_ok && (err_magic_q != '1)) begin
            err_magic_d = err_magic_q + CNT_W'(1);
        end
        case (state_q)
            RUN:     if (HALT_ON_ERR && frame_err) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            err_magic_q <= '0;
        end else begin
            state_q     <= state_d;
            err_magic_q <= err_magic_d;
        end
    end

    assign wr_entry.payload = msg.payload;
    assign wr_entry.seq_err = seq_bad || off_bad;

    hq_fifo_reader_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (rx_pop_o && magic_ok),
        .wr_data_i  (wr_entry),
        .rd_en_i    (rd_valid_o && rd_ready_i),
        .rd_data_o  (rd_entry),
        .rd_valid_o (rd_valid_o),
        .count_o    (buf_count)
    );

    assign rd_msg_o     = rd_entry.payload;
    assign rd_seq_err_o = rd_entry.seq_err;
    assign err_magic_o  = err_magic_q;
    assign halted_o     = (state_q == HALT);

endmodule
